// File: rtl/buzzer_sequencer_if.sv
// Host-side bundle for the buzzer sequencer: score writes, playback control,
// status flags and the drive signals towards the tone generator.
interface buzzer_sequencer_if;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [3:0]  start_addr;
    logic        loop;
    logic        stop;
    logic        busy;
    logic        done;
    logic [3:0]  cur_addr;
    logic        buzz_enable;
    logic [3:0]  buzz_note;
    logic [2:0]  buzz_octave;

    modport master (
        output wr_en, wr_addr, wr_data, start, start_addr, loop, stop,
        input  busy, done, cur_addr, buzz_enable, buzz_note, buzz_octave
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, start_addr, loop, stop,
        output busy, done, cur_addr, buzz_enable, buzz_note, buzz_octave
    );
endinterface

// File: rtl/buzzer_sequencer.sv
// Steps through a 16-entry host-written score and drives note/octave/enable
// of the buzzer tone generator, with per-entry durations, gaps and looping.
module buzzer_sequencer #(
    parameter int TICK_CYCLES = 500000,
    parameter int GAP_CYCLES  = 0
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    buzzer_sequencer_if.slave bus
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;

    logic [15:0] score_q [16];

    state_t        state_q, state_d;
    logic [3:0]    cur_addr_q, cur_addr_d;
    logic [3:0]    start_addr_q, start_addr_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    ticks_q, ticks_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          buzz_enable_q, buzz_enable_d;
    logic [3:0]    buzz_note_q, buzz_note_d;
    logic [2:0]    buzz_octave_q, buzz_octave_d;

    logic [15:0]   entry;
    logic          entry_rest;
    logic [7:0]    entry_dur;
    logic          advance;

    // Score storage survives reset so the host does not have to reload it.
    always_ff @(posedge clk_50mhz) begin
        if (bus.wr_en) begin
            score_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        entry         = score_q[cur_addr_q];
        entry_rest    = (entry[3:0] >= 4'd12);
        entry_dur     = (entry[14:7] == 8'd0) ? 8'd1 : entry[14:7];
        advance       = 1'b0;
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        start_addr_d  = start_addr_q;
        presc_d       = presc_q;
        ticks_d       = ticks_q;
        gap_d         = gap_q;
        last_d        = last_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        buzz_enable_d = buzz_enable_q;
        buzz_note_d   = buzz_note_q;
        buzz_octave_d = buzz_octave_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    start_addr_d = bus.start_addr;
                    cur_addr_d   = bus.start_addr;
                    busy_d       = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                buzz_note_d   = entry_rest ? 4'd0 : entry[3:0];
                buzz_octave_d = entry[6:4];
                buzz_enable_d = !entry_rest;
                ticks_d       = entry_dur;
                last_d        = entry[15];
                presc_d       = '0;
                state_d       = S_PLAY;
            end
            S_PLAY: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    ticks_d = ticks_q - 8'd1;
                    if (ticks_q == 8'd1) begin
                        buzz_enable_d = 1'b0;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = '0;
                            state_d = S_GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The last flag was captured at fetch; loop is sampled live here.
        if (advance) begin
            buzz_enable_d = 1'b0;
            if (!last_q) begin
                cur_addr_d = cur_addr_q + 4'd1;
                state_d    = S_FETCH;
            end else if (bus.loop) begin
                cur_addr_d = start_addr_q;
                state_d    = S_FETCH;
            end else begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
        end

        if (bus.stop) begin
            state_d       = S_IDLE;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            buzz_enable_d = 1'b0;
            cur_addr_d    = cur_addr_q;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= '0;
            start_addr_q  <= '0;
            presc_q       <= '0;
            ticks_q       <= '0;
            gap_q         <= '0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            buzz_enable_q <= 1'b0;
            buzz_note_q   <= '0;
            buzz_octave_q <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            start_addr_q  <= start_addr_d;
            presc_q       <= presc_d;
            ticks_q       <= ticks_d;
            gap_q         <= gap_d;
            last_q        <= last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            buzz_enable_q <= buzz_enable_d;
            buzz_note_q   <= buzz_note_d;
            buzz_octave_q <= buzz_octave_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cur_addr    = cur_addr_q;
    assign bus.buzz_enable = buzz_enable_q;
    assign bus.buzz_note   = buzz_note_q;
    assign bus.buzz_octave = buzz_octave_q;
endmodule

// File: tb/tb_buzzer_sequencer.sv
// Self-checking bench for buzzer_sequencer: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a timeline model.
module tb_buzzer_sequencer;
    localparam int TICK = 4;
    localparam int GAP  = 2;
    localparam int MI = 0, MF = 1, MS = 2, MG = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    buzzer_sequencer_if bus_if();

    buzzer_sequencer #(.TICK_CYCLES(TICK), .GAP_CYCLES(GAP)) dut (
        .clk_50mhz(clk),
        .rst_n    (rst_n),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;
    bit cmp_on = 1'b0;

    // Model: each entry is a silent fetch cycle, then duration*TICK sounding
    // cycles, then GAP silent cycles, tracked as a plain countdown.
    logic [15:0] m_mem [16];
    logic [15:0] m_e;
    int          m_mode = MI;
    int          m_remain = 0;
    int          m_dur;
    logic [3:0]  m_cur = 0, m_start = 0, m_note = 0;
    logic [2:0]  m_oct = 0;
    logic        m_last = 0, m_en = 0, m_busy = 0, m_done = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_advance();
        if (!m_last) begin
            m_cur  = m_cur + 4'd1;
            m_mode = MF;
        end else if (bus_if.loop) begin
            m_cur  = m_start;
            m_mode = MF;
        end else begin
            m_mode = MI;
            m_busy = 1'b0;
            m_done = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = MI; m_remain = 0; m_cur = 0; m_start = 0; m_note = 0;
            m_oct = 0; m_last = 0; m_en = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = 1'b0;
            if (bus_if.stop) begin
                m_mode = MI; m_en = 1'b0; m_busy = 1'b0;
            end else begin
                case (m_mode)
                    MI: if (bus_if.start) begin
                        m_start = bus_if.start_addr;
                        m_cur   = bus_if.start_addr;
                        m_busy  = 1'b1;
                        m_mode  = MF;
                    end
                    MF: begin
                        m_e      = m_mem[m_cur];
                        m_dur    = (m_e[14:7] == 8'd0) ? 1 : int'(m_e[14:7]);
                        m_remain = m_dur * TICK;
                        m_last   = m_e[15];
                        m_oct    = m_e[6:4];
                        if (m_e[3:0] >= 4'd12) begin m_note = 0; m_en = 1'b0; end
                        else begin m_note = m_e[3:0]; m_en = 1'b1; end
                        m_mode = MS;
                    end
                    MS: begin
                        m_remain--;
                        if (m_remain == 0) begin
                            m_en = 1'b0;
                            if (GAP > 0) begin m_mode = MG; m_remain = GAP; end
                            else model_advance();
                        end
                    end
                    default: begin
                        m_remain--;
                        if (m_remain == 0) model_advance();
                    end
                endcase
            end
            if (bus_if.wr_en) m_mem[bus_if.wr_addr] = bus_if.wr_data;
        end
    end

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            check_output("busy", bus_if.busy, m_busy);
            check_output("done", bus_if.done, m_done);
            check_output("cur_addr", bus_if.cur_addr, m_cur);
            check_output("buzz_enable", bus_if.buzz_enable, m_en);
            if (m_en) begin
                check_output("buzz_note", bus_if.buzz_note, m_note);
                check_output("buzz_octave", bus_if.buzz_octave, m_oct);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic apply_write(input int addr, input int note, input int oct, input int dur, input bit last);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = 4'(addr);
        bus_if.wr_data = {last, 8'(dur), 3'(oct), 4'(note)};
        tick();
        bus_if.wr_en = 1'b0;
    endtask

    task automatic apply_start(input int addr);
        bus_if.start      = 1'b1;
        bus_if.start_addr = 4'(addr);
        tick();
        bus_if.start = 1'b0;
    endtask

    task automatic apply_stop();
        bus_if.stop = 1'b1;
        tick();
        bus_if.stop = 1'b0;
    endtask

    task automatic wait_enable(input logic val, input string name);
        int n = 0;
        while (bus_if.buzz_enable !== val && n < 100) begin tick(); n++; end
        check_output({name, " wait"}, 32'(n < 100), 1);
    endtask

    // Runs until busy drops, recording the address sequence and enable-high run lengths.
    int      seq_cycles;
    int      addr_q[$];
    int      runs_q[$];
    task automatic record_run();
        int run = 0;
        seq_cycles = 0;
        addr_q.delete();
        runs_q.delete();
        while (bus_if.busy === 1'b1 && seq_cycles < 300) begin
            if (addr_q.size() == 0 || addr_q[$] != int'(bus_if.cur_addr)) addr_q.push_back(int'(bus_if.cur_addr));
            if (bus_if.buzz_enable) run++;
            else if (run > 0) begin runs_q.push_back(run); run = 0; end
            seq_cycles++;
            tick();
        end
    endtask

    initial begin
        int n;
        bus_if.wr_en = 0; bus_if.wr_addr = 0; bus_if.wr_data = 0;
        bus_if.start = 0; bus_if.start_addr = 0; bus_if.loop = 0; bus_if.stop = 0;

        #2 rst_n = 1'b0;
        #1;
        check_output("reset busy", bus_if.busy, 0);
        check_output("reset enable", bus_if.buzz_enable, 0);
        check_output("reset cur_addr", bus_if.cur_addr, 0);
        repeat (2) tick();
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        tick();
        check_output("idle busy", bus_if.busy, 0);
        for (int a = 0; a < 16; a++) apply_write(a, 1, 0, 1, 1'b0);

        // Single note: 12 sounding cycles, 2 silent, then done.
        apply_write(0, 9, 4, 3, 1'b1);
        apply_start(0);
        check_output("single busy after E0", bus_if.busy, 1);
        tick();
        check_output("single enable", bus_if.buzz_enable, 1);
        check_output("single note", bus_if.buzz_note, 9);
        check_output("single octave", bus_if.buzz_octave, 4);
        n = 0;
        while (bus_if.buzz_enable === 1'b1 && n < 100) begin n++; tick(); end
        check_output("single enable cycles", n, 12);
        n = 1;
        while (bus_if.done !== 1'b1 && n < 20) begin tick(); n++; end
        check_output("single done position", n, 3);
        check_output("single busy at done", bus_if.busy, 0);

        // Rest and sequencing.
        apply_write(0, 0, 2, 1, 1'b0);
        apply_write(1, 15, 2, 2, 1'b0);
        apply_write(2, 11, 2, 1, 1'b1);
        apply_start(0);
        record_run();
        check_output("seq busy cycles", seq_cycles, 25);
        check_output("seq addr count", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check_output("seq addr0", addr_q[0], 0);
            check_output("seq addr1", addr_q[1], 1);
            check_output("seq addr2", addr_q[2], 2);
        end
        check_output("seq run count", runs_q.size(), 2);
        if (runs_q.size() == 2) begin
            check_output("seq run0", runs_q[0], 4);
            check_output("seq run1", runs_q[1], 4);
        end
        check_output("seq done", bus_if.done, 1);

        // Loop, then stop mid-play.
        bus_if.loop = 1'b1;
        apply_start(0);
        addr_q.delete();
        n = 0;
        while (addr_q.size() < 4 && n < 200) begin
            if (addr_q.size() == 0 || addr_q[$] != int'(bus_if.cur_addr)) addr_q.push_back(int'(bus_if.cur_addr));
            if (addr_q.size() < 4) begin tick(); n++; end
        end
        check_output("loop returns to 0", (addr_q.size() == 4) ? addr_q[3] : 99, 0);
        wait_enable(1'b1, "loop replay");
        apply_stop();
        check_output("stop busy", bus_if.busy, 0);
        check_output("stop enable", bus_if.buzz_enable, 0);
        check_output("stop done", bus_if.done, 0);
        check_output("stop cur_addr", bus_if.cur_addr, 0);
        tick();
        check_output("stop no late done", bus_if.done, 0);
        bus_if.loop = 1'b0;

        // Wrap-around from 15 to 0.
        apply_write(15, 5, 2, 1, 1'b0);
        apply_write(0, 7, 1, 1, 1'b1);
        apply_start(15);
        record_run();
        check_output("wrap busy cycles", seq_cycles, 14);
        check_output("wrap first", (addr_q.size() > 0) ? addr_q[0] : 99, 15);
        check_output("wrap second", (addr_q.size() > 1) ? addr_q[1] : 99, 0);
        check_output("wrap done", bus_if.done, 1);

        // Start while busy is ignored.
        apply_start(15);
        repeat (2) tick();
        apply_start(3);
        check_output("restart ignored addr", bus_if.cur_addr, 15);
        record_run();
        check_output("restart ignored done", bus_if.done, 1);

        // Start and stop together from idle.
        bus_if.stop = 1'b1;
        apply_start(0);
        bus_if.stop = 1'b0;
        check_output("start+stop busy", bus_if.busy, 0);
        tick();
        check_output("start+stop still idle", bus_if.busy, 0);

        // Asynchronous reset during play.
        apply_start(15);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_output("async reset busy", bus_if.busy, 0);
        check_output("async reset enable", bus_if.buzz_enable, 0);
        check_output("async reset cur_addr", bus_if.cur_addr, 0);
        check_output("async reset note", bus_if.buzz_note, 0);
        check_output("async reset octave", bus_if.buzz_octave, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_output("post reset busy", bus_if.busy, 0);

        // Rewrite the entry that is sounding.
        apply_write(0, 2, 3, 2, 1'b1);
        bus_if.loop = 1'b1;
        apply_start(0);
        tick();
        check_output("rewrite enable", bus_if.buzz_enable, 1);
        check_output("rewrite note before", bus_if.buzz_note, 2);
        apply_write(0, 6, 3, 2, 1'b1);
        check_output("rewrite note held", bus_if.buzz_note, 2);
        wait_enable(1'b0, "rewrite gap");
        wait_enable(1'b1, "rewrite next pass");
        check_output("rewrite note after", bus_if.buzz_note, 6);
        apply_stop();
        bus_if.loop = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus_if.wr_en = ($urandom_range(0, 7) == 0);
            bus_if.wr_addr = 4'($urandom_range(0, 15));
            bus_if.wr_data = {($urandom_range(0, 2) == 0), 8'($urandom_range(0, 3)),
                              3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            bus_if.start = ($urandom_range(0, 9) == 0);
            bus_if.start_addr = 4'($urandom_range(0, 15));
            bus_if.stop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 49) == 0) bus_if.loop = ~bus_if.loop;
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            tick();
        end
        bus_if.wr_en = 0; bus_if.start = 0; bus_if.loop = 0;
        apply_stop();
        tick();
        check_output("final idle", bus_if.busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Plays a stored melody by driving the note/octave/enable inputs of the square-wave buzzer tone generator. It holds a 16-entry score memory written by the host, then steps through the entries on a start command, holding each note for a programmable number of duration ticks, with optional inter-note silence and looping. It sits between the host/control logic and the buzzer. The tone generator itself is unchanged.

## Interface
- TICK_CYCLES, 500000: clk_50mhz cycles per duration tick (10 ms at 50 MHz); legal range ≥1.
- GAP_CYCLES, 0: silent cycles inserted after every played entry; 0 means no gap state.
- clk_50mhz  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  score write strobe.
- wr_addr  in  4  score entry address.
- wr_data  in  16  entry fields: [3:0] note, [6:4] octave, [14:7] duration in ticks, [15] last.
- start  in  1  begin playback; honoured only in IDLE.
- start_addr  in  4  first entry; latched when start is accepted.
- loop  in  1  sampled at each last entry; 1 restarts from the latched start_addr.
- stop  in  1  abort playback; takes priority over start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a non-looping sequence ends naturally.
- cur_addr  out  4  address of the entry currently fetched or playing.
- buzz_enable  out  1  buzzer enable.
- buzz_note  out  4  note code sent to the buzzer, 0–11.
- buzz_octave  out  3  octave sent to the buzzer.

## Operation
- Score memory: 16×16 registers, written on the clock edge when wr_en=1. Writes are allowed in any state. Reads are combinational from cur_addr. The memory is not cleared by reset.
- **IDLE**: buzz_enable=0 and busy=0.
  - start=1 and stop=0: latch start_addr, set cur_addr=start_addr, go to FETCH.
- **FETCH** (exactly 1 cycle): buzz_enable=0.
  - Load buzz_note and buzz_octave from the entry.
  - Load the tick counter with the duration; duration 0 is treated as 1.
  - Clear the prescaler and go to PLAY.
  - A rest entry (note code 12–15) loads buzz_note=0 and keeps buzz_enable=0 during PLAY.
- **PLAY**: buzz_enable=1, unless the entry is a rest.
  - The prescaler counts 0..TICK_CYCLES-1. At wrap the tick counter decrements.
  - When the final tick expires, go to GAP if GAP_CYCLES>0, otherwise go straight to the advance decision.
- **GAP**: buzz_enable=0 for GAP_CYCLES cycles, then the advance decision.
- **Advance decision**, taken on the same edge that leaves PLAY or GAP:
  - last=0: cur_addr+1 (15 wraps to 0), go to FETCH.
  - last=1 and loop=1: cur_addr=latched start_addr, go to FETCH.
  - last=1 and loop=0: go to IDLE, assert done for 1 cycle, buzz_enable=0.
- A score with no last flag plays cyclically through all 16 entries until stop.
- stop=1 in any state: go to IDLE on the next edge. buzz_enable=0, no done pulse, cur_addr holds.
- start while busy is ignored.
- A write to an entry on the same edge it is fetched: the fetch uses the old data. Later passes use the new data.

## Timing
- Reset values: state IDLE; busy=0, done=0, buzz_enable=0, buzz_note=0, buzz_octave=0, cur_addr=0; prescaler, tick counter and latched start address all 0.
- All outputs are registered.
- Start latency: start sampled at edge E0 → busy=1 after E0 → note, octave and enable valid after E1.
- Playing entry length: exactly duration×TICK_CYCLES cycles with buzz_enable high.
- Entry-to-entry period: 1 + duration×TICK_CYCLES + GAP_CYCLES cycles; includes 1 silent FETCH cycle.
- done is asserted in the first IDLE cycle after the last entry; busy falls in that same cycle.
- Reset mid-operation returns all state to reset values immediately (asynchronous).

## Test plan
- Reset: hold rst_n=0 during play → all outputs 0 immediately. After release, state is IDLE and busy=0.
- Single note (TICK_CYCLES=4, GAP_CYCLES=2): write addr0 = note 9, octave 4, dur 3, last; pulse start with start_addr=0.
  - buzz_enable=1, note=9, octave=4 for 12 cycles starting 2 edges after start.
  - Then 2 silent cycles, then a done pulse and busy=0.
- Rest and sequencing: addr0 note 0/dur 1; addr1 note 15/dur 2; addr2 note 11/dur 1/last.
  - Enable is high 4 cycles, low for rest 8 cycles, high 4 cycles.
  - cur_addr steps 0,1,2.
- Loop and stop: same score with loop=1 → cur_addr returns to 0 after entry 2. Assert stop mid-PLAY → IDLE next edge, enable=0, no done.
- Wrap-around: entry 15 with last=0, entry 0 with last=1; start_addr=15 → plays 15 then 0, then done.
- Conflicts:
  - start while busy: no restart.
  - start and stop in the same cycle from IDLE: stays IDLE.
  - Write to the playing entry: the current note is unchanged; the new data is heard on the next loop pass.
